// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] addr;
  logic            we;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rdata;
  logic            rsp_err;

  modport master (
    output req_valid, addr, we, wstrb, wdata,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  modport slave (
    input  req_valid, addr, we, wstrb, wdata,
    output req_ready, rsp_valid, rdata, rsp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory stage: one data-memory transaction at a time, returns extended
// load data to writeback or raises a precise exception.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ex_valid,
  output logic            o_ex_ready,
  input  logic            i_ex_load,
  input  logic            i_ex_store,
  input  logic [2:0]      i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_addr,
  input  logic [XLEN-1:0] i_ex_wdata,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_flush,
  load_store_unit_if.master mem,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_exc_valid,
  output logic [3:0]      o_exc_cause,
  output logic [XLEN-1:0] o_exc_addr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            is_load_q;
  logic            killed_q;
  logic            wb_pend_q;
  logic            exc_pend_q;
  logic            req_valid_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            mem_we_q;
  logic [3:0]      mem_wstrb_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [3:0]      dec_cause;
  logic            accept;

  // Returns 0 when the op is legal and aligned, otherwise the mcause code.
  function automatic logic [3:0] decode_cause(input logic ld, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic legal;
    logic mis;
    legal = ld ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    mis = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    if (!legal) return 4'd2;
    if (mis) return ld ? 4'd4 : 4'd6;
    return 4'd0;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [XLEN-1:0] w);
    logic [XLEN-1:0] s;
    s = w >> {off, 3'b000};
    case (f3)
      3'd0:    return {{(XLEN-8){s[7]}}, s[7:0]};
      3'd1:    return {{(XLEN-16){s[15]}}, s[15:0]};
      3'd4:    return {{(XLEN-8){1'b0}}, s[7:0]};
      3'd5:    return {{(XLEN-16){1'b0}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign dec_cause = decode_cause(i_ex_load, i_ex_funct3, i_ex_addr[1:0]);
  assign accept    = i_ex_valid && o_ex_ready && (i_ex_load || i_ex_store) && !i_flush;

  assign mem.req_valid = req_valid_q;
  assign mem.addr      = mem_addr_q;
  assign mem.we        = mem_we_q;
  assign mem.wstrb     = mem_wstrb_q;
  assign mem.wdata     = mem_wdata_q;

  // A flush arriving while the result is on display still cancels it.
  assign o_wb_valid  = wb_pend_q && !i_flush;
  assign o_exc_valid = exc_pend_q && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_ex_ready  <= 1'b1;
      addr_q      <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      is_load_q   <= 1'b0;
      killed_q    <= 1'b0;
      wb_pend_q   <= 1'b0;
      exc_pend_q  <= 1'b0;
      req_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      o_wb_rd     <= '0;
      o_wb_data   <= '0;
      o_exc_cause <= '0;
      o_exc_addr  <= '0;
    end else begin
      wb_pend_q   <= 1'b0;
      exc_pend_q  <= 1'b0;
      o_wb_rd     <= '0;
      o_wb_data   <= '0;
      o_exc_cause <= '0;
      o_exc_addr  <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= i_ex_addr;
            funct3_q   <= i_ex_funct3;
            rd_q       <= i_ex_rd;
            is_load_q  <= i_ex_load;
            killed_q   <= 1'b0;
            o_ex_ready <= 1'b0;
            if (dec_cause != 4'd0) begin
              state       <= RESP;
              exc_pend_q  <= 1'b1;
              o_exc_cause <= dec_cause;
              o_exc_addr  <= i_ex_addr;
            end else begin
              state       <= REQ;
              req_valid_q <= 1'b1;
              mem_addr_q  <= {i_ex_addr[XLEN-1:2], 2'b00};
              mem_we_q    <= !i_ex_load;
              mem_wstrb_q <= i_ex_load ? 4'b0000 : store_strb(i_ex_funct3, i_ex_addr[1:0]);
              mem_wdata_q <= i_ex_load ? '0 : store_data(i_ex_funct3, i_ex_wdata);
            end
          end
        end
        REQ: begin
          if (mem.req_ready || i_flush) begin
            req_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
          end
          // A handshake already happened on the bus, so the response must still be drained.
          if (mem.req_ready) begin
            state    <= WAIT;
            killed_q <= i_flush;
          end else if (i_flush) begin
            state      <= IDLE;
            o_ex_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (mem.rsp_valid) begin
            if (killed_q || i_flush) begin
              state      <= IDLE;
              o_ex_ready <= 1'b1;
              killed_q   <= 1'b0;
            end else begin
              state <= RESP;
              if (mem.rsp_err) begin
                exc_pend_q  <= 1'b1;
                o_exc_cause <= is_load_q ? 4'd5 : 4'd7;
                o_exc_addr  <= addr_q;
              end else if (is_load_q && rd_q != 5'd0) begin
                wb_pend_q <= 1'b1;
                o_wb_rd   <= rd_q;
                o_wb_data <= load_extend(funct3_q, addr_q[1:0], mem.rdata);
              end
            end
          end else if (i_flush) begin
            killed_q <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          o_ex_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single ops plus hand-written
// sequences for stalls, flushes and mid-transaction reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store, flush;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_ready, wb_valid, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [3:0]  exc_cause;

  int checks = 0;
  int errors = 0;
  string tag = "";

  load_store_unit_if #(.XLEN(32)) mem();

  load_store_unit #(.XLEN(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ex_valid  (ex_valid),
    .o_ex_ready  (ex_ready),
    .i_ex_load   (ex_load),
    .i_ex_store  (ex_store),
    .i_ex_funct3 (ex_funct3),
    .i_ex_addr   (ex_addr),
    .i_ex_wdata  (ex_wdata),
    .i_ex_rd     (ex_rd),
    .i_flush     (flush),
    .mem         (mem),
    .o_wb_valid  (wb_valid),
    .o_wb_rd     (wb_rd),
    .o_wb_data   (wb_data),
    .o_exc_valid (exc_valid),
    .o_exc_cause (exc_cause),
    .o_exc_addr  (exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    logic        exp_req;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_wb;
    logic [31:0] exp_data;
    logic        exp_exc;
    logic [3:0]  exp_cause;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got 0x%08h, expected 0x%08h", tag, name, act, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'd0;
    ex_addr = '0; ex_wdata = '0; ex_rd = '0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("ex_ready_idle", 32'(ex_ready), 32'd1);
    issue(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
    @(negedge clk);
    idle_inputs();
    if (!v.exp_req) begin
      chk("no_req", 32'(mem.req_valid), 32'd0);
      chk("exc_valid", 32'(exc_valid), 32'(v.exp_exc));
      chk("exc_cause", 32'(exc_cause), 32'(v.exp_cause));
      chk("exc_addr", exc_addr, v.addr);
      chk("wb_valid", 32'(wb_valid), 32'd0);
      @(negedge clk);
      chk("ex_ready_after", 32'(ex_ready), 32'd1);
    end else begin
      chk("req_valid", 32'(mem.req_valid), 32'd1);
      chk("mem_addr", mem.addr, {v.addr[31:2], 2'b00});
      chk("mem_we", 32'(mem.we), 32'(v.st && !v.ld));
      if (v.st && !v.ld) begin
        chk("mem_wstrb", 32'(mem.wstrb), 32'(v.exp_wstrb));
        chk("mem_wdata", mem.wdata, v.exp_wdata);
      end
      mem.req_ready = 1'b1;
      @(negedge clk);
      mem.req_ready = 1'b0;
      chk("req_dropped", 32'(mem.req_valid), 32'd0);
      chk("ex_ready_wait", 32'(ex_ready), 32'd0);
      mem.rsp_valid = 1'b1; mem.rdata = v.rdata; mem.rsp_err = v.err;
      @(negedge clk);
      mem.rsp_valid = 1'b0; mem.rdata = '0; mem.rsp_err = 1'b0;
      chk("wb_valid", 32'(wb_valid), 32'(v.exp_wb));
      chk("exc_valid", 32'(exc_valid), 32'(v.exp_exc));
      if (v.exp_wb) begin
        chk("wb_data", wb_data, v.exp_data);
        chk("wb_rd", 32'(wb_rd), 32'(v.rd));
      end
      if (v.exp_exc) begin
        chk("exc_cause", 32'(exc_cause), 32'(v.exp_cause));
        chk("exc_addr", exc_addr, v.addr);
      end
      @(negedge clk);
      chk("ex_ready_after", 32'(ex_ready), 32'd1);
      chk("wb_cleared", 32'(wb_valid), 32'd0);
    end
  endtask

  initial begin
    //          ld st f3 addr          wdata         rd     rdata         err req wstrb    exp_wdata     wb exp_data      exc cause
    vecs[0]  = '{1, 0, 0, 32'h1003, 32'h0,        5'd5,  32'h80FF_FF11, 0, 1, 4'h0,    32'h0,        1, 32'hFFFF_FF80, 0, 4'd0};
    vecs[1]  = '{1, 0, 4, 32'h1003, 32'h0,        5'd6,  32'h80FF_FF11, 0, 1, 4'h0,    32'h0,        1, 32'h0000_0080, 0, 4'd0};
    vecs[2]  = '{1, 0, 1, 32'h1002, 32'h0,        5'd7,  32'h8001_1234, 0, 1, 4'h0,    32'h0,        1, 32'hFFFF_8001, 0, 4'd0};
    vecs[3]  = '{1, 0, 5, 32'h1000, 32'h0,        5'd8,  32'h8001_F234, 0, 1, 4'h0,    32'h0,        1, 32'h0000_F234, 0, 4'd0};
    vecs[4]  = '{1, 0, 2, 32'h1004, 32'h0,        5'd31, 32'hDEAD_BEEF, 0, 1, 4'h0,    32'h0,        1, 32'hDEAD_BEEF, 0, 4'd0};
    vecs[5]  = '{1, 0, 2, 32'h1008, 32'h0,        5'd0,  32'h1234_5678, 0, 1, 4'h0,    32'h0,        0, 32'h0,         0, 4'd0};
    vecs[6]  = '{0, 1, 0, 32'h2001, 32'h1234_56A5, 5'd0, 32'h0,         0, 1, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0,         0, 4'd0};
    vecs[7]  = '{0, 1, 1, 32'h2002, 32'h0000_ABCD, 5'd0, 32'h0,         0, 1, 4'b1100, 32'hABCD_ABCD, 0, 32'h0,         0, 4'd0};
    vecs[8]  = '{0, 1, 2, 32'h2004, 32'hCAFE_F00D, 5'd0, 32'h0,         0, 1, 4'b1111, 32'hCAFE_F00D, 0, 32'h0,         0, 4'd0};
    vecs[9]  = '{1, 0, 2, 32'h3001, 32'h0,        5'd1,  32'h0,         0, 0, 4'h0,    32'h0,        0, 32'h0,         1, 4'd4};
    vecs[10] = '{0, 1, 1, 32'h3001, 32'h0,        5'd0,  32'h0,         0, 0, 4'h0,    32'h0,        0, 32'h0,         1, 4'd6};
    vecs[11] = '{1, 0, 3, 32'h3000, 32'h0,        5'd2,  32'h0,         0, 0, 4'h0,    32'h0,        0, 32'h0,         1, 4'd2};
    vecs[12] = '{0, 1, 4, 32'h3000, 32'h0,        5'd0,  32'h0,         0, 0, 4'h0,    32'h0,        0, 32'h0,         1, 4'd2};
    vecs[13] = '{1, 0, 0, 32'h4000, 32'h0,        5'd9,  32'h0,         1, 1, 4'h0,    32'h0,        0, 32'h0,         1, 4'd5};
    vecs[14] = '{1, 1, 2, 32'h0100, 32'h55,       5'd10, 32'h0102_0304, 0, 1, 4'h0,    32'h0,        1, 32'h0102_0304, 0, 4'd0};

    rst = 1'b1; flush = 1'b0; idle_inputs();
    mem.req_ready = 1'b0; mem.rsp_valid = 1'b0; mem.rdata = '0; mem.rsp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    tag = "reset";
    chk("ex_ready", 32'(ex_ready), 32'd1);
    chk("req_valid", 32'(mem.req_valid), 32'd0);
    chk("wb_valid", 32'(wb_valid), 32'd0);
    chk("exc_valid", 32'(exc_valid), 32'd0);
    chk("mem_addr", mem.addr, 32'd0);

    for (int i = 0; i < 15; i++) begin
      tag = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    // Store stalled by the bus for three cycles, then faulted.
    tag = "sw_stall";
    @(negedge clk);
    issue(1'b0, 1'b1, 3'd2, 32'h5008, 32'h1122_3344, 5'd0);
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      chk("req_valid", 32'(mem.req_valid), 32'd1);
      chk("mem_addr", mem.addr, 32'h5008);
      chk("mem_wstrb", 32'(mem.wstrb), 32'hF);
      chk("mem_wdata", mem.wdata, 32'h1122_3344);
      if (c == 3) mem.req_ready = 1'b1;
      @(negedge clk);
    end
    mem.req_ready = 1'b0;
    mem.rsp_valid = 1'b1; mem.rsp_err = 1'b1;
    @(negedge clk);
    mem.rsp_valid = 1'b0; mem.rsp_err = 1'b0;
    chk("exc_valid", 32'(exc_valid), 32'd1);
    chk("exc_cause", 32'(exc_cause), 32'd7);
    chk("exc_addr", exc_addr, 32'h5008);
    chk("wb_valid", 32'(wb_valid), 32'd0);

    // LHU flushed while waiting: response drained silently.
    tag = "flush_wait";
    @(negedge clk);
    issue(1'b1, 1'b0, 3'd5, 32'h10, 32'h0, 5'd4);
    @(negedge clk);
    idle_inputs();
    mem.req_ready = 1'b1;
    @(negedge clk);
    mem.req_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("ex_ready_wait", 32'(ex_ready), 32'd0);
    mem.rsp_valid = 1'b1; mem.rdata = 32'h0000_BEEF;
    @(negedge clk);
    mem.rsp_valid = 1'b0; mem.rdata = '0;
    chk("wb_valid", 32'(wb_valid), 32'd0);
    chk("exc_valid", 32'(exc_valid), 32'd0);
    chk("ex_ready", 32'(ex_ready), 32'd1);

    // Flush on the accept cycle drops the op.
    tag = "flush_idle";
    issue(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 5'd3);
    flush = 1'b1;
    @(negedge clk);
    idle_inputs(); flush = 1'b0;
    chk("req_valid", 32'(mem.req_valid), 32'd0);
    chk("ex_ready", 32'(ex_ready), 32'd1);

    // Flush in REQ without handshake returns to IDLE.
    tag = "flush_req";
    issue(1'b1, 1'b0, 3'd2, 32'h44, 32'h0, 5'd3);
    @(negedge clk);
    idle_inputs();
    chk("req_valid", 32'(mem.req_valid), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("req_valid", 32'(mem.req_valid), 32'd0);
    chk("ex_ready", 32'(ex_ready), 32'd1);
    chk("exc_valid", 32'(exc_valid), 32'd0);

    // Accept with neither load nor store is a no-op.
    tag = "noop";
    issue(1'b0, 1'b0, 3'd2, 32'h48, 32'h0, 5'd3);
    @(negedge clk);
    idle_inputs();
    chk("req_valid", 32'(mem.req_valid), 32'd0);
    chk("ex_ready", 32'(ex_ready), 32'd1);
    chk("exc_valid", 32'(exc_valid), 32'd0);

    // Flush during RESP suppresses the writeback pulse.
    tag = "flush_resp";
    issue(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 5'd3);
    @(negedge clk);
    idle_inputs();
    mem.req_ready = 1'b1;
    @(negedge clk);
    mem.req_ready = 1'b0;
    mem.rsp_valid = 1'b1; mem.rdata = 32'h7777_0001;
    @(negedge clk);
    mem.rsp_valid = 1'b0; mem.rdata = '0;
    flush = 1'b1;
    #1;
    chk("wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("ex_ready", 32'(ex_ready), 32'd1);

    // Reset mid-transaction returns straight to IDLE.
    tag = "mid_reset";
    issue(1'b1, 1'b0, 3'd2, 32'h24, 32'h0, 5'd3);
    @(negedge clk);
    idle_inputs();
    chk("req_valid", 32'(mem.req_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("req_valid", 32'(mem.req_valid), 32'd0);
    chk("ex_ready", 32'(ex_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
